// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: framing FSM states and bit-timing constants used by both TX and RX.
package uart_tx_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 104;
    localparam int DIV_W                = 11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake from a producer into the UART transmitter.
interface uart_tx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: power-of-two circular FIFO with registered occupancy.
// Latency: a pushed entry is visible at head on the next cycle.
// Backpressure: push is ignored when full, pop is ignored when empty.
module uart_tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the framing FSM.
// Latency: a byte pushed into an idle block starts its start bit two cycles later.
// Backpressure: ready drops while the FIFO is full or reset is asserted.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    uart_tx_if.slave   tx_if,
    output logic       uartTxPin,
    output logic       busy,
    output logic       fin
);

    uart_state_t      state, state_n;
    logic [DIV_W-1:0] div, div_n;
    logic [2:0]       bitcnt, bitcnt_n;
    logic [7:0]       shift, shift_n;
    logic             tx_n;
    logic             fin_n;
    logic             pop;
    logic             full;
    logic             empty;
    logic [7:0]       head;
    logic             last;

    assign tx_if.ready = reset && !full;
    assign busy        = (state != IDLE) || !empty;
    assign last        = (div == DIV_W'(CLKS_PER_BIT - 1));

    uart_tx_fifo #(
        .WIDTH      (8),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_if.valid && tx_if.ready),
        .wdata (tx_if.data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        state_n  = state;
        div_n    = div;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_n  = head;
                    div_n    = '0;
                    bitcnt_n = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (last) begin
                    div_n   = '0;
                    state_n = DATA;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            DATA: begin
                if (last) begin
                    div_n    = '0;
                    shift_n  = {1'b0, shift[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = STOP;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            STOP: begin
                if (last) begin
                    div_n = '0;
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_n  = head;
                        bitcnt_n = '0;
                        state_n  = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Line and fin are registered from next-state so they align exactly with the state they describe.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
        fin_n = (state_n == STOP) && (div_n == DIV_W'(CLKS_PER_BIT - 1));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            div       <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            uartTxPin <= 1'b1;
            fin       <= 1'b0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            bitcnt    <= bitcnt_n;
            shift     <= shift_n;
            uartTxPin <= tx_n;
            fin       <= fin_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks/bit) for timing and FIFO scenarios,
// and a 104 clocks/bit instance looped into a bench-side receiver.
module tb_uart_tx;

    logic clock;
    logic reset;
    logic tx_fast, busy_fast, fin_fast;
    logic tx_slow, busy_slow, fin_slow;
    logic [7:0] rxq[$];
    logic [7:0] rxq_slow[$];
    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_if fif ();
    uart_tx_if sif ();

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_if     (fif),
        .uartTxPin (tx_fast),
        .busy      (busy_fast),
        .fin       (fin_fast)
    );

    uart_tx #(.CLKS_PER_BIT(104), .FIFO_DEPTH(4)) dut_slow (
        .clock     (clock),
        .reset     (reset),
        .tx_if     (sif),
        .uartTxPin (tx_slow),
        .busy      (busy_slow),
        .fin       (fin_slow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic line(input bit slow);
        return slow ? tx_slow : tx_fast;
    endfunction

    // Mid-bit sampling receiver; the detecting negedge is the first low cycle of the frame.
    task automatic rx_loop(input int cpb, input bit slow);
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && line(slow) === 1'b0) begin
                repeat (cpb / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clock);
                    b[i] = line(slow);
                end
                repeat (cpb) @(negedge clock);
                if (slow) rxq_slow.push_back(b);
                else      rxq.push_back(b);
            end
        end
    endtask

    initial rx_loop(4, 1'b0);
    initial rx_loop(104, 1'b1);

    task automatic test_reset();
        reset = 1'b0;
        fif.valid = 1'b0; fif.data = 8'h00;
        sif.valid = 1'b0; sif.data = 8'h00;
        repeat (3) @(negedge clock);
        n_checks++; if (tx_fast !== 1'b1)   begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx_fast); end
        n_checks++; if (fif.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", fif.ready); end
        n_checks++; if (busy_fast !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_fast); end
        n_checks++; if (fin_fast !== 1'b0)  begin n_fail++; $display("FAIL reset_fin got=%b exp=0", fin_fast); end
        n_checks++; if (sif.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_slow got=%b exp=0", sif.ready); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (fif.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", fif.ready); end
        n_checks++; if (sif.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_slow got=%b exp=1", sif.ready); end
    endtask

    task automatic test_single_frame();
        logic [0:9] pat;
        pat = 10'b0101001011;  // 0xA5: start, 1,0,1,0,0,1,0,1, stop
        rxq.delete();
        @(negedge clock); fif.data = 8'hA5; fif.valid = 1'b1;
        @(negedge clock); fif.valid = 1'b0;
        n_checks++; if (tx_fast !== 1'b1) begin n_fail++; $display("FAIL a5_latency tx=%b exp=1", tx_fast); end
        @(negedge clock);
        for (int o = 0; o < 40; o++) begin
            n_checks++; if (tx_fast !== pat[o/4]) begin n_fail++; $display("FAIL a5_bit off=%0d tx=%b exp=%b", o, tx_fast, pat[o/4]); end
            n_checks++; if (fin_fast !== (o == 39)) begin n_fail++; $display("FAIL a5_fin off=%0d fin=%b exp=%b", o, fin_fast, (o == 39)); end
            if (o == 20) begin
                n_checks++; if (busy_fast !== 1'b1) begin n_fail++; $display("FAIL a5_busy_mid got=%b exp=1", busy_fast); end
            end
            @(negedge clock);
        end
        n_checks++; if (busy_fast !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end got=%b exp=0", busy_fast); end
        n_checks++; if (tx_fast !== 1'b1)   begin n_fail++; $display("FAIL a5_idle_tx got=%b exp=1", tx_fast); end
        n_checks++; if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin n_fail++; $display("FAIL a5_rx size=%0d exp=1 byte A5", rxq.size()); end
    endtask

    task automatic test_back_to_back();
        logic [0:9] pa, pb;
        logic exp;
        int nfin;
        int fin_at[2];
        pa = 10'b0000000001;   // 0x00
        pb = 10'b0111111111;   // 0xFF
        nfin = 0; fin_at[0] = -1; fin_at[1] = -1;
        rxq.delete();
        @(negedge clock); fif.data = 8'h00; fif.valid = 1'b1;
        @(negedge clock); fif.data = 8'hFF;
        @(negedge clock); fif.valid = 1'b0;
        for (int o = 0; o < 80; o++) begin
            exp = (o < 40) ? pa[o/4] : pb[(o-40)/4];
            n_checks++; if (tx_fast !== exp) begin n_fail++; $display("FAIL b2b_bit off=%0d tx=%b exp=%b", o, tx_fast, exp); end
            if (fin_fast === 1'b1) begin
                if (nfin < 2) fin_at[nfin] = o;
                nfin++;
            end
            @(negedge clock);
        end
        n_checks++; if (nfin != 2)       begin n_fail++; $display("FAIL b2b_fin_count got=%0d exp=2", nfin); end
        n_checks++; if (fin_at[0] != 39) begin n_fail++; $display("FAIL b2b_fin0 got=%0d exp=39", fin_at[0]); end
        n_checks++; if (fin_at[1] != 79) begin n_fail++; $display("FAIL b2b_fin1 got=%0d exp=79", fin_at[1]); end
        n_checks++; if (busy_fast !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got=%b exp=0", busy_fast); end
        n_checks++; if (rxq.size() != 2 || rxq[0] !== 8'h00 || rxq[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx size=%0d exp=2 bytes 00 FF", rxq.size()); end
    endtask

    task automatic test_fifo_full();
        // The first pop coincides with the second push, so five bytes fit before full;
        // the sixth lands one cycle after the pop at the end of the first frame.
        int exp_t[6] = '{0, 1, 2, 3, 4, 42};
        int acc_t[6];
        int k, t;
        logic rd, r5;
        k = 0; t = 0; r5 = 1'bx;
        rxq.delete();
        while (k < 6 && t < 100) begin
            fif.data = 8'h10 + 8'(k); fif.valid = 1'b1;
            rd = fif.ready;
            if (t == 5) r5 = rd;
            @(negedge clock);
            if (rd === 1'b1) begin acc_t[k] = t; k++; end
            t++;
        end
        fif.valid = 1'b0;
        n_checks++; if (k != 6) begin n_fail++; $display("FAIL full_accept_count got=%0d exp=6", k); end
        n_checks++; if (r5 !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", r5); end
        for (int i = 0; i < k; i++) begin
            n_checks++; if (acc_t[i] != exp_t[i]) begin n_fail++; $display("FAIL full_accept_cycle idx=%0d got=%0d exp=%0d", i, acc_t[i], exp_t[i]); end
        end
        for (int i = 0; i < 400 && rxq.size() < 6; i++) @(negedge clock);
        n_checks++; if (rxq.size() != 6) begin n_fail++; $display("FAIL full_rx_count got=%0d exp=6", rxq.size()); end
        for (int i = 0; i < 6 && i < rxq.size(); i++) begin
            n_checks++; if (rxq[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL full_rx_byte idx=%0d got=%h exp=%h", i, rxq[i], 8'h10 + 8'(i)); end
        end
        repeat (5) @(negedge clock);
        n_checks++; if (busy_fast !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got=%b exp=0", busy_fast); end
    endtask

    task automatic test_reset_midframe();
        int lows;
        rxq.delete();
        @(negedge clock); fif.data = 8'h80; fif.valid = 1'b1;
        @(negedge clock); fif.data = 8'h11;
        @(negedge clock); fif.data = 8'h22;   // first low cycle of the 0x80 frame
        @(negedge clock); fif.valid = 1'b0;
        repeat (14) @(negedge clock);
        // Offset 15 is inside data bit 2 of 0x80, which is low.
        n_checks++; if (tx_fast !== 1'b0) begin n_fail++; $display("FAIL mid_pre_tx got=%b exp=0", tx_fast); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (tx_fast !== 1'b1)   begin n_fail++; $display("FAIL mid_tx got=%b exp=1", tx_fast); end
        n_checks++; if (busy_fast !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy_fast); end
        n_checks++; if (fin_fast !== 1'b0)  begin n_fail++; $display("FAIL mid_fin got=%b exp=0", fin_fast); end
        n_checks++; if (fif.ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", fif.ready); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (fif.ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got=%b exp=1", fif.ready); end
        n_checks++; if (busy_fast !== 1'b0) begin n_fail++; $display("FAIL mid_release_busy got=%b exp=0", busy_fast); end
        lows = 0;
        repeat (150) begin
            @(negedge clock);
            if (tx_fast !== 1'b1) lows++;
        end
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL mid_queued_sent low_cycles=%0d exp=0", lows); end
        rxq.delete();
    endtask

    task automatic test_loopback();
        logic [7:0] exp_b[3] = '{8'h55, 8'h3C, 8'h80};
        rxq_slow.delete();
        @(negedge clock); sif.data = 8'h55; sif.valid = 1'b1;
        @(negedge clock); sif.data = 8'h3C;
        @(negedge clock); sif.data = 8'h80;
        @(negedge clock); sif.valid = 1'b0;
        for (int i = 0; i < 4000 && rxq_slow.size() < 3; i++) @(negedge clock);
        n_checks++; if (rxq_slow.size() != 3) begin n_fail++; $display("FAIL loop_rx_count got=%0d exp=3", rxq_slow.size()); end
        for (int i = 0; i < 3 && i < rxq_slow.size(); i++) begin
            n_checks++; if (rxq_slow[i] !== exp_b[i]) begin n_fail++; $display("FAIL loop_rx_byte idx=%0d got=%h exp=%h", i, rxq_slow[i], exp_b[i]); end
        end
        for (int i = 0; i < 200 && busy_slow !== 1'b0; i++) @(negedge clock);
        n_checks++; if (busy_slow !== 1'b0) begin n_fail++; $display("FAIL loop_busy_end got=%b exp=0", busy_slow); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
